// File: rtl/clint_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp behind a single-outstanding MMIO port.
// Optional tick prescaler enabled by defining MTIMER_PRESCALE_EN.
module clint_mtimer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  output logic        rsp_valid_o,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        timer_int_o
);

  localparam logic [63:0] CMP_ADDR  = BASE_ADDR + 64'h4000;
  localparam logic [63:0] TIME_ADDR = BASE_ADDR + 64'hBFF8;

  typedef enum logic {IDLE, RESP} state_e;

  state_e      state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        int_q, int_d;
  logic        accept, hit_time, hit_cmp;
  logic        wr_time, wr_cmp, tick;
  logic        unused_addr;

  function automatic logic [63:0] merge(
    input logic [63:0] old,
    input logic [63:0] wd,
    input logic [7:0]  m
  );
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++)
      if (m[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  assign unused_addr = ^req_addr_i[2:0];
  assign accept   = (state_q == IDLE) && req_valid_i;
  assign hit_time = (req_addr_i[63:3] == TIME_ADDR[63:3]);
  assign hit_cmp  = (req_addr_i[63:3] == CMP_ADDR[63:3]);
  // An all-zero mask is a true no-op: it must not stall the tick.
  assign wr_time  = accept && req_wen_i && hit_time && (|req_wmask_i);
  assign wr_cmp   = accept && req_wen_i && hit_cmp;

`ifdef MTIMER_PRESCALE_EN
  logic [15:0] pcnt_q, pcnt_d;

  assign tick = (pcnt_q == 16'(TICK_DIV - 1));

  always_comb begin
    pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
    if (wr_time) pcnt_d = 16'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pcnt_q <= 16'd0;
    else        pcnt_q <= pcnt_d;
  end
`else
  logic unused_tick_div;
  assign unused_tick_div = ^TICK_DIV;
  assign tick = 1'b1;
`endif

  always_comb begin
    state_d    = IDLE;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    int_d      = (mtime_q >= mtimecmp_q);
    rdata_d    = '0;
    err_d      = 1'b0;
    if (wr_time) mtime_d = merge(mtime_q, req_wdata_i, req_wmask_i);
    if (wr_cmp)
      mtimecmp_d = merge(mtimecmp_q, req_wdata_i, req_wmask_i);
    if (accept) begin
      state_d = RESP;
      unique case (1'b1)
        hit_time: rdata_d = req_wen_i ? '0 : mtime_q;
        hit_cmp:  rdata_d = req_wen_i ? '0 : mtimecmp_q;
        default:  err_d   = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      int_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      int_q      <= int_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign timer_int_o = int_q;

endmodule

// File: tb/tb_clint_mtimer.sv
// Bench for clint_mtimer: reference model plus response scoreboard,
// a vector table and hand-written corner sequences.
module tb_clint_mtimer;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_CMP = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
`ifdef MTIMER_PRESCALE_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  logic        clk = 0;
  logic        rst_n = 0;
  logic        req_valid = 0;
  logic        req_ready_o;
  logic        req_wen = 0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        timer_int_o;

  clint_mtimer #(.BASE_ADDR(BASE), .TICK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_wen_i(req_wen), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .timer_int_o(timer_int_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [15:0] off;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic        use_model;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  logic [63:0] m_time, m_cmp;
  logic        m_int, m_busy;
  int          m_pcnt;

  function automatic logic [63:0] bmerge(
    input logic [63:0] o, input logic [63:0] w, input logic [7:0] m
  );
    logic [63:0] r;
    r = o;
    for (int k = 0; k < 8; k++)
      if (m[k]) r[8*k +: 8] = w[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model, advanced on every rising edge.
  always @(posedge clk) begin
    logic acc, tk, hit_t, hit_c;
    logic [63:0] nt, nc;
    if (!rst_n) begin
      m_time = '0; m_cmp = '1; m_int = 0; m_busy = 0; m_pcnt = 0;
      sb.delete();
    end else begin
      acc   = req_valid && !m_busy;
      hit_t = req_addr[63:3] == A_TIME[63:3];
      hit_c = req_addr[63:3] == A_CMP[63:3];
      tk    = (m_pcnt == DIV - 1);
      m_pcnt = tk ? 0 : m_pcnt + 1;
      nt = tk ? m_time + 64'd1 : m_time;
      nc = m_cmp;
      if (acc && req_wen && hit_t && req_wmask != 0) begin
        nt = bmerge(m_time, req_wdata, req_wmask);
        m_pcnt = 0;
      end
      if (acc && req_wen && hit_c) nc = bmerge(m_cmp, req_wdata, req_wmask);
      m_int  = (m_time >= m_cmp);
      m_time = nt;
      m_cmp  = nc;
      m_busy = acc;
    end
  end

  // Per-cycle output checks and scoreboard pop.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en && rst_n) begin
      chk("ready", {63'd0, req_ready_o}, {63'd0, !m_busy});
      chk("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, m_busy});
      chk("timer_int", {63'd0, timer_int_o}, {63'd0, m_int});
      if (m_busy) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_err", {63'd0, rsp_err_o}, {63'd0, e.err});
        end
      end
    end
  end

  task automatic access(input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] mask,
                        input logic [63:0] erd, input logic eerr);
    sb.push_back('{erd, eerr});
    req_valid = 1; req_wen = wen; req_addr = addr;
    req_wdata = wdata; req_wmask = mask;
    @(posedge clk); #1;
    req_valid = 0; req_wen = 0; req_wmask = '0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  vec_t vt[11];
  int   n;

  initial begin
    vt[0]  = '{0, 16'h4000, 64'd0, 8'h00, 0, '1, 0};
    vt[1]  = '{0, 16'h1000, 64'd0, 8'h00, 0, 64'd0, 1};
    vt[2]  = '{1, 16'h4000, 64'd0, 8'h00, 0, 64'd0, 0};
    vt[3]  = '{0, 16'h4000, 64'd0, 8'h00, 0, '1, 0};
    vt[4]  = '{1, 16'h4000, 64'h1234, 8'h03, 0, 64'd0, 0};
    vt[5]  = '{0, 16'h4004, 64'd0, 8'h00, 0, 64'hFFFF_FFFF_FFFF_1234, 0};
    vt[6]  = '{0, 16'hBFF0, 64'd0, 8'h00, 0, 64'd0, 1};
    vt[7]  = '{1, 16'hBFF0, '1, 8'hFF, 0, 64'd0, 1};
    vt[8]  = '{0, 16'hBFF8, 64'd0, 8'h00, 1, 64'd0, 0};
    vt[9]  = '{1, 16'h4000, '1, 8'hFF, 0, 64'd0, 0};
    vt[10] = '{0, 16'hC000, 64'd0, 8'h00, 0, 64'd0, 1};

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk_en = 1;

    // Idle after reset, then read mtime and mtimecmp.
    repeat (10) @(posedge clk);
    #1;
    chk("int_idle", {63'd0, timer_int_o}, 64'd0);
    access(0, A_TIME, '0, '0, m_time, 0);
    access(0, A_CMP, '0, '0, '1, 0);

    foreach (vt[i]) begin
      access(vt[i].wen, BASE + {48'd0, vt[i].off}, vt[i].wdata,
             vt[i].mask, vt[i].use_model ? m_time : vt[i].rdata,
             vt[i].err);
    end

    // Compare hit: interrupt rises one edge after mtime reaches 20.
    do_reset();
    access(1, A_CMP, 64'd20, 8'hFF, 64'd0, 0);
    n = 0;
    while (!timer_int_o && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("int_rise_seen", {63'd0, timer_int_o}, 64'd1);
`ifdef MTIMER_PRESCALE_EN
    chk("int_rise_time", m_time, 64'd20);
`else
    chk("int_rise_time", m_time, 64'd21);
`endif
    access(1, A_CMP, 64'd1000, 8'hFF, 64'd0, 0);
    chk("int_cleared", {63'd0, timer_int_o}, 64'd0);

    // Wrap of mtime against max compare.
    do_reset();
    access(1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, 0);
`ifndef MTIMER_PRESCALE_EN
    @(posedge clk); #1;
    chk("int_at_max", {63'd0, timer_int_o}, 64'd1);
    @(posedge clk); #1;
    chk("int_after_wrap", {63'd0, timer_int_o}, 64'd0);
`endif
    repeat (8) @(posedge clk);
    #1;

    // Byte-masked mtime write on a tick edge.
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    access(1, A_TIME, 64'h1122_3344_5566_7788, 8'h0F, 64'd0, 0);
`ifdef MTIMER_PRESCALE_EN
    access(0, A_TIME, '0, '0, 64'h0000_0000_5566_7788, 0);
`else
    access(0, A_TIME, '0, '0, 64'h0000_0000_5566_7789, 0);
`endif

    // Back-to-back valid: second request waits out the response cycle.
    sb.push_back('{m_cmp, 1'b0});
    sb.push_back('{m_cmp, 1'b0});
    req_valid = 1; req_wen = 0; req_addr = A_CMP;
    @(posedge clk); #1;
    chk("ready_in_resp", {63'd0, req_ready_o}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #1;

    // Reset during the response cycle.
    req_valid = 1; req_wen = 1; req_addr = A_CMP;
    req_wdata = 64'd5; req_wmask = 8'hFF;
    sb.push_back('{64'd0, 1'b0});
    @(posedge clk); #1;
    req_valid = 0; req_wen = 0; req_wmask = '0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    repeat (21) @(posedge clk);
    #1;
    access(0, A_TIME, '0, '0, m_time, 0);
    access(0, A_CMP, '0, '0, '1, 0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
